piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter that is the partner of the team's serial-in shift register. It accepts an N-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock, with a bit-enable strobe. A downstream shift register clocked on the same `clk` rebuilds the word by sampling `sout`/`sen` as its `d`/`en`. It sits between a word-oriented producer and a single-wire serial link.

---
 rtl/piso_serializer_pkg.sv | 12 +
 rtl/piso_serializer_if.sv | 27 ++
 rtl/piso_serializer_bit_counter.sv | 28 ++
 rtl/piso_serializer.sv | 79 +++++++
 tb/tb_piso_serializer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in serial-out transmitter and
// its framing helpers.
package piso_pkg;

   typedef enum logic {
      PISO_IDLE  = 1'b0,
      PISO_SHIFT = 1'b1
   } piso_state_e;

   localparam int PISO_N_DEFAULT = 8;

endpackage

// File: rtl/piso_serializer_if.sv
// Word-load handshake plus serial link signals of the serializer.
// The producer drives through master; the serializer sits on slave.
interface piso_serializer_if
   import piso_pkg::*;
#(
   parameter int N = PISO_N_DEFAULT
);

   logic         load_valid;
   logic [N-1:0] load_data;
   logic         load_ready;
   logic         sout;
   logic         sen;
   logic         done;
   logic         busy;

   modport master (
      output load_valid, load_data,
      input  load_ready, sout, sen, done, busy
   );

   modport slave (
      input  load_valid, load_data,
      output load_ready, sout, sen, done, busy
   );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Loadable down-counter with a zero flag, used for bit framing on either end
// of the serial link. It holds at zero rather than wrapping.
module bit_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Serializes N-bit words MSB-first with a bit-enable strobe; a new word may be
// accepted in the last-bit cycle so consecutive words leave with no gap.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int N = PISO_N_DEFAULT
) (
   input logic              clk,
   input logic              rstn,
   piso_serializer_if.slave bus
);

   localparam int            CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   piso_state_e  state_q, state_d;
   logic [N-1:0] sreg_q;
   logic         cnt_zero;
   logic         ready;
   logic         accept;
   logic         cnt_dec;

   bit_counter #(.W(CW)) u_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load     (accept),
      .load_val (LAST_IDX),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Ready only depends on state and counter, never on load_valid.
   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      accept  = 1'b0;
      cnt_dec = 1'b0;
      case (state_q)
         PISO_IDLE: begin
            ready  = 1'b1;
            accept = bus.load_valid;
            if (accept) state_d = PISO_SHIFT;
         end
         PISO_SHIFT: begin
            ready   = cnt_zero;
            accept  = bus.load_valid && cnt_zero;
            cnt_dec = !cnt_zero;
            if (cnt_zero && !accept) state_d = PISO_IDLE;
         end
         default: state_d = PISO_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= PISO_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // After the last shift the register is all zeros, so sout idles low.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sreg_q <= '0;
      end else if (accept) begin
         sreg_q <= bus.load_data;
      end else if (state_q == PISO_SHIFT) begin
         sreg_q <= {sreg_q[N-2:0], 1'b0};
      end
   end

   assign bus.load_ready = ready;
   assign bus.sout       = sreg_q[N-1];
   assign bus.sen        = (state_q == PISO_SHIFT);
   assign bus.busy       = (state_q == PISO_SHIFT);
   assign bus.done       = (state_q == PISO_SHIFT) && cnt_zero;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios plus a random loopback run
// against a bit-queue reference model and a serial-in receiver.
module tb_piso_serializer;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  piso_serializer_if #(.N(8)) bus8 ();
  piso_serializer_if #(.N(4)) bus4 ();

  piso_serializer #(.N(8)) dut  (.clk(clk), .rstn(rstn), .bus(bus8));
  piso_serializer #(.N(4)) dut4 (.clk(clk), .rstn(rstn), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: queue of bits still to be sent; ready when at most one remains.
  bit         mq[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      sent_q.delete();
    end else begin
      bit acc;
      acc = bus8.load_valid && (mq.size() <= 1);
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        sent_q.push_back(bus8.load_data);
        for (int k = 7; k >= 0; k--) mq.push_back(bus8.load_data[k]);
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) rx <= '0;
    else if (bus8.sen) rx <= {rx[6:0], bus8.sout};
  end

  task automatic test_reset;
    logic [4:0] got;
    rstn = 1'b0;
    bus8.load_valid = 1'b1;
    bus8.load_data  = 8'hFF;
    bus4.load_valid = 1'b1;
    bus4.load_data  = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
    total++;
    if (got !== 5'b00001) begin
      bad++;
      $display("FAIL reset8 outputs: got %b want 00001", got);
    end
    got = {bus4.sout, bus4.sen, bus4.done, bus4.busy, bus4.load_ready};
    total++;
    if (got !== 5'b00001) begin
      bad++;
      $display("FAIL reset4 outputs: got %b want 00001", got);
    end
    bus8.load_valid = 1'b0;
    bus4.load_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    got = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
    total++;
    if (got !== 5'b00001) begin
      bad++;
      $display("FAIL reset_no_capture: got %b want 00001", got);
    end
  endtask

  task automatic test_single;
    logic [7:0] w = 8'hA5;
    logic [4:0] got, exp;
    @(negedge clk);
    bus8.load_valid = 1'b1;
    bus8.load_data  = w;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {w[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
      got = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single cycle %0d: got %b want %b", i + 1, got, exp);
      end
      if (i == 0) bus8.load_valid = 1'b0;
    end
    @(negedge clk);
    got = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
    total++;
    if (got !== 5'b00001) begin
      bad++;
      $display("FAIL single idle: got %b want 00001", got);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s = 16'hA53C;
    logic [4:0]  got, exp;
    logic        last;
    @(negedge clk);
    bus8.load_valid = 1'b1;
    bus8.load_data  = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      last = (i == 7) || (i == 15);
      exp  = {s[15-i], 1'b1, last, 1'b1, last};
      got  = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL b2b cycle %0d: got %b want %b", i + 1, got, exp);
      end
      if (i == 0) bus8.load_data = 8'h3C;
      if (i == 8) bus8.load_valid = 1'b0;
    end
    @(negedge clk);
    got = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
    total++;
    if (got !== 5'b00001) begin
      bad++;
      $display("FAIL b2b idle: got %b want 00001", got);
    end
  endtask

  task automatic test_stall;
    logic [15:0] s = 16'h00FF;
    logic [4:0]  got, exp;
    logic        last;
    @(negedge clk);
    bus8.load_valid = 1'b1;
    bus8.load_data  = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      last = (i == 7) || (i == 15);
      exp  = {s[15-i], 1'b1, last, 1'b1, last};
      got  = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL stall cycle %0d: got %b want %b", i + 1, got, exp);
      end
      if (i == 0) bus8.load_valid = 1'b0;
      if (i == 2) begin
        bus8.load_valid = 1'b1;
        bus8.load_data  = 8'hFF;
      end
      if (i == 3) bus8.load_data = 8'h5A;
      if (i == 5) bus8.load_data = 8'hFF;
      if (i == 8) bus8.load_valid = 1'b0;
    end
    @(negedge clk);
    got = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
    total++;
    if (got !== 5'b00001) begin
      bad++;
      $display("FAIL stall idle: got %b want 00001", got);
    end
  endtask

  task automatic test_reset_midword;
    logic [7:0] w = 8'hC3;
    logic [7:0] w2 = 8'h81;
    logic [4:0] got, exp;
    @(negedge clk);
    bus8.load_valid = 1'b1;
    bus8.load_data  = w;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus8.sout, bus8.sen} !== {w[7-i], 1'b1}) begin
        bad++;
        $display("FAIL midword bit %0d: got %b want %b", i + 1, {bus8.sout, bus8.sen}, {w[7-i], 1'b1});
      end
      if (i == 0) bus8.load_valid = 1'b0;
    end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    got = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
    total++;
    if (got !== 5'b00001) begin
      bad++;
      $display("FAIL midword async reset: got %b want 00001", got);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    got = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
    total++;
    if (got !== 5'b00001) begin
      bad++;
      $display("FAIL midword after release: got %b want 00001", got);
    end
    bus8.load_valid = 1'b1;
    bus8.load_data  = w2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {w2[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
      got = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL post-reset word cycle %0d: got %b want %b", i + 1, got, exp);
      end
      if (i == 0) bus8.load_valid = 1'b0;
    end
  endtask

  task automatic test_loopback;
    @(negedge clk);
    sent_q.delete();
    fork
      begin
        for (int w = 0; w < 50; w++) begin
          int g;
          int gap;
          bit rdy;
          bus8.load_data  = 8'($urandom);
          bus8.load_valid = 1'b1;
          g = 0;
          do begin
            rdy = bus8.load_ready;
            @(negedge clk);
            g++;
          end while (!rdy && g < 64);
          gap = $urandom_range(0, 3);
          if (gap > 0) begin
            bus8.load_valid = 1'b0;
            repeat (gap) @(negedge clk);
          end
        end
        bus8.load_valid = 1'b0;
      end
      begin
        int         cyc;
        int         words;
        bit         pend;
        logic [7:0] ew;
        logic       ebit;
        logic [4:0] got, exp;
        cyc   = 0;
        words = 0;
        pend  = 1'b0;
        while (words < 50 && cyc < 4000) begin
          @(negedge clk);
          cyc++;
          if (pend) begin
            pend = 1'b0;
            words++;
            total++;
            if (sent_q.size() == 0) begin
              bad++;
              $display("FAIL loopback word %0d: no word recorded as sent", words);
            end else begin
              ew = sent_q.pop_front();
              if (rx !== ew) begin
                bad++;
                $display("FAIL loopback word %0d: rx %h want %h", words, rx, ew);
              end
            end
          end
          ebit = (mq.size() > 0) ? mq[0] : 1'b0;
          exp  = {ebit, mq.size() > 0, mq.size() == 1, mq.size() > 0, mq.size() <= 1};
          got  = {bus8.sout, bus8.sen, bus8.done, bus8.busy, bus8.load_ready};
          total++;
          if (got !== exp) begin
            bad++;
            $display("FAIL loopback cycle %0d: got %b want %b", cyc, got, exp);
          end
          if (mq.size() == 1) pend = 1'b1;
        end
        if (words < 50) begin
          total++;
          bad++;
          $display("FAIL loopback timeout: words %0d want 50", words);
        end
      end
    join
  endtask

  task automatic test_n4;
    logic [3:0] w = 4'b1001;
    logic [3:0] got, exp;
    @(negedge clk);
    bus4.load_valid = 1'b1;
    bus4.load_data  = w;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = {w[3-i], 1'b1, (i == 3), (i == 3)};
      got = {bus4.sout, bus4.sen, bus4.done, bus4.load_ready};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL n4 cycle %0d: got %b want %b", i + 1, got, exp);
      end
      if (i == 0) bus4.load_valid = 1'b0;
    end
    @(negedge clk);
    got = {bus4.sout, bus4.sen, bus4.done, bus4.load_ready};
    total++;
    if (got !== 4'b0001) begin
      bad++;
      $display("FAIL n4 idle: got %b want 0001", got);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    bus8.load_valid = 1'b0;
    bus8.load_data  = '0;
    bus4.load_valid = 1'b0;
    bus4.load_data  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_midword();
    test_loopback();
    test_n4();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
